// File: rtl/timer_irq_dev.sv
// timer_irq_dev: bus-mapped programmable down-counter with one interrupt line.
// Mode 0 is one-shot with a sticky flag; mode 1 auto-reloads and pulses the flag
// for a single cycle. The flag is acknowledged by any write to CTRL or PRESET.
// A PRESET of 0 is handled like 1: the terminal test is COUNT <= 1, so COUNT
// never wraps below zero.

module timer_irq_dev #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] ModePeriod = 2'd1;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;
    // Set for the cycle after a periodic interrupt so the flag drops one edge later.
    logic             pulse_q, pulse_d;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == AddrCtrl);
    assign preset_wr = we && (addr == AddrPreset);

    // Next-state: FSM step first, then bus writes take priority over it.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        pulse_d    = 1'b0;

        // End of the one-cycle periodic pulse.
        if (pulse_q) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (en_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    // Disabled mid-count: COUNT stays frozen for software to inspect.
                    state_d = StIdle;
                end else if (count_q > CntOne) begin
                    count_d = count_q - CntOne;
                end else begin
                    count_d = '0;
                    state_d = StInt;
                end
            end
            StInt: begin
                irq_flag_d = 1'b1;
                state_d    = StIdle;
                if (mode_q == ModePeriod) begin
                    pulse_d = 1'b1;
                end else begin
                    // One-shot and reserved modes stop after a single expiry.
                    en_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (ctrl_wr) begin
            en_d   = wdata[0];
            mode_d = wdata[2:1];
            im_d   = wdata[3];
        end

        if (preset_wr) begin
            preset_d = wdata[CNT_W-1:0];
        end

        // Software acknowledge beats a flag set on the same edge.
        if (ctrl_wr || preset_wr) begin
            irq_flag_d = 1'b0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            pulse_q    <= pulse_d;
        end
    end

    // Combinational register read, zero-extended to the bus width.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            AddrCtrl:   rdata = {28'd0, im_q, mode_q, en_q};
            AddrPreset: rdata = 32'(preset_q);
            AddrCount:  rdata = 32'(count_q);
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_flag_q & im_q;

endmodule

// File: tb/tb_timer_irq_dev.sv
// Testbench for timer_irq_dev: directed scenarios plus random bus traffic, all
// checked against a timeline model that tracks when a run was loaded and the
// edge at which it expires, deriving COUNT from elapsed edges.

module tb_timer_irq_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    timer_irq_dev #(
        .CNT_W(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_en, m_im, m_flag, m_active;
    bit [1:0]    m_mode;
    bit [31:0]   m_preset, m_count, m_loaded;
    longint      m_edge       = 0;
    longint      m_load_edge  = -1;
    longint      m_int_edge   = -1;
    longint      m_clear_edge = -1;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_edge(input bit r, input bit w, input logic [1:0] a,
                              input logic [31:0] d);
        bit        o_en;
        bit [1:0]  o_mode;
        bit [31:0] o_preset;
        m_edge++;
        if (r) begin
            m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
            m_flag = 0; m_active = 0; m_clear_edge = -1;
            return;
        end
        o_en     = m_en;
        o_mode   = m_mode;
        o_preset = m_preset;
        if (m_edge == m_clear_edge) m_flag = 0;
        if (!m_active) begin
            // Idle: an enabled timer starts a run; the load happens one edge later.
            if (o_en) begin
                m_active    = 1;
                m_load_edge = m_edge + 1;
            end
        end else if (m_edge == m_load_edge) begin
            m_count    = o_preset;
            m_loaded   = o_preset;
            m_int_edge = m_edge + ((o_preset == 0) ? 1 : longint'(o_preset));
        end else if (m_edge <= m_int_edge) begin
            if (!o_en)                   m_active = 0;
            else if (m_edge == m_int_edge) m_count = 0;
            else                         m_count = m_loaded - 32'(m_edge - m_load_edge);
        end else begin
            // Expiry edge: raise the flag and finish the run.
            m_flag   = 1;
            m_active = 0;
            if (o_mode == 2'd1) m_clear_edge = m_edge + 1;
            else                m_en = 0;
        end
        if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
        end
        if (w && a == 2'd1) begin
            m_preset = d; m_flag = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_all();
        check_eq("irq", {31'd0, irq}, {31'd0, m_flag & m_im});
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check_eq($sformatf("rdata[%0d]", a), rdata, m_read(2'(a)));
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        reset = r; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        reset = 1'b0; we = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    logic [31:0] v;
    logic [31:0] rnd;

    initial begin
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;

        // Reset, then reset again in the middle of a count.
        step(1, 0, 2'd0, 0);
        step(1, 0, 2'd0, 0);
        step(0, 1, 2'd1, 32'd9);
        step(0, 1, 2'd0, 32'h9);
        idle(5);
        step(1, 0, 2'd0, 0);
        step(1, 0, 2'd0, 0);
        idle(1);
        read_reg(2'd2, v);
        check_eq("t1_count_after_reset", v, 32'd0);

        // One-shot, sticky flag, acknowledge by CTRL write.
        step(0, 1, 2'd1, 32'd3);
        step(0, 1, 2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            if (k >= 2 && k <= 5) begin
                read_reg(2'd2, v);
                check_eq("t2_count", v, 32'(5 - k));
            end
        end
        check_eq("t2_irq_set", {31'd0, irq}, 32'd1);
        read_reg(2'd0, v);
        check_eq("t2_ctrl_en_cleared", v, 32'h8);
        idle(3);
        check_eq("t2_irq_sticky", {31'd0, irq}, 32'd1);
        step(0, 1, 2'd0, 32'h8);
        check_eq("t2_irq_ack", {31'd0, irq}, 32'd0);

        // Periodic mode, pulses every PRESET+3 cycles.
        step(0, 1, 2'd1, 32'd2);
        step(0, 1, 2'd0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            check_eq("t3_pulse", {31'd0, irq}, {31'd0, (k == 5 || k == 10 || k == 15)});
        end
        step(0, 1, 2'd0, 32'h0);
        idle(12);

        // PRESET of zero, then masked expiry and acknowledge.
        step(0, 1, 2'd1, 32'd0);
        step(0, 1, 2'd0, 32'h9);
        idle(5);
        step(0, 1, 2'd0, 32'h1);
        idle(6);
        check_eq("t4_masked_irq", {31'd0, irq}, 32'd0);
        step(0, 1, 2'd0, 32'h8);
        check_eq("t4_ack_irq", {31'd0, irq}, 32'd0);

        // Disable mid-count, then restart with a fresh PRESET.
        step(0, 1, 2'd1, 32'd10);
        step(0, 1, 2'd0, 32'h9);
        idle(5);
        step(0, 1, 2'd0, 32'h8);
        idle(4);
        step(0, 1, 2'd1, 32'd4);
        step(0, 1, 2'd0, 32'h9);
        idle(8);

        // Writes to COUNT and to the unused slot during a count.
        step(0, 1, 2'd1, 32'd6);
        step(0, 1, 2'd0, 32'h9);
        idle(3);
        step(0, 1, 2'd2, 32'h55);
        step(0, 1, 2'd3, 32'hFFFF_FFFF);
        read_reg(2'd3, v);
        check_eq("t6_unused_reads_zero", v, 32'd0);
        idle(8);
        step(0, 1, 2'd0, 32'h0);

        // Random bus traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          r, w;
            logic [1:0]  a;
            logic [31:0] d;
            r   = ($urandom_range(0, 149) == 0);
            w   = ($urandom_range(0, 7) == 0);
            a   = 2'($urandom_range(0, 3));
            rnd = $urandom();
            if (a == 2'd1)      d = 32'($urandom_range(0, 7));
            else if (a == 2'd0) d = {rnd[31:4], rnd[3:1], ($urandom_range(0, 3) != 0)};
            else                d = rnd;
            step(r, w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
